// File: rtl/seq_det_prog.sv
// seq_det_prog: runtime-programmable serial pattern detector with overlap control and saturating match counter
module seq_det_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int MEALY   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_load_i,
  input  logic [MAX_LEN-1:0]           cfg_pattern_i,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len_i,
  input  logic                         cfg_overlap_i,
  input  logic                         in_valid_i,
  input  logic                         in_bit_i,
  input  logic                         cnt_clr_i,
  output logic                         match_o,
  output logic [CNT_W-1:0]             match_count_o,
  output logic [1:0]                   det_state_o
);
  localparam int LW = $clog2(MAX_LEN+1);
  typedef enum logic [1:0] {UNCFG = 2'd0, FILL = 2'd1, ARMED = 2'd2} state_t;
  state_t             state_q;
  logic [MAX_LEN-1:0] pattern_q, hist_q, win, mask;
  logic [LW-1:0]      len_q, len_d, fill_q, fill_d;
  logic [LW:0]        fill_inc;
  logic               overlap_q, match_q, accept, fill_ok, hit, restart;
  logic [CNT_W-1:0]   cnt_q;
  always_comb begin
    len_d    = cfg_len_i == '0 ? LW'(1) : cfg_len_i > LW'(MAX_LEN) ? LW'(MAX_LEN) : cfg_len_i;
    win      = {hist_q[MAX_LEN-2:0], in_bit_i};
    mask     = {MAX_LEN{1'b1}} >> (LW'(MAX_LEN) - len_q);
    fill_inc = {1'b0, fill_q} + (LW+1)'(1);
    fill_ok  = fill_inc >= {1'b0, len_q};
    fill_d   = fill_inc > (LW+1)'(MAX_LEN) ? LW'(MAX_LEN) : fill_inc[LW-1:0];
    accept   = in_valid_i & (state_q != UNCFG) & ~cfg_load_i;
    hit      = accept & fill_ok & ~|((win ^ pattern_q) & mask);
    // a non-overlapping hit discards history so the next match needs len fresh bits
    restart  = hit & ~overlap_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UNCFG;
      pattern_q <= '0;
      len_q     <= LW'(1);
      overlap_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      match_q <= hit;
      cnt_q   <= cnt_clr_i ? '0 : cnt_q + CNT_W'(hit & ~&cnt_q);
      if (cfg_load_i) begin
        pattern_q <= cfg_pattern_i;
        len_q     <= len_d;
        overlap_q <= cfg_overlap_i;
        hist_q    <= '0;
        fill_q    <= '0;
        state_q   <= FILL;
      end else if (accept) begin
        hist_q  <= restart ? '0 : win;
        fill_q  <= restart ? '0 : fill_d;
        state_q <= restart ? FILL : fill_ok ? ARMED : state_q;
      end
    end
  end
  assign match_o       = MEALY != 0 ? hit : match_q;
  assign match_count_o = cnt_q;
  assign det_state_o   = state_q;
endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: table-driven scoreboard bench for seq_det_prog (16-bit and 2-bit counter instances)
module tb_seq_det_prog;
  logic clk = 1'b0;
  logic rst, cfg_load, cfg_overlap, in_valid, in_bit, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic match0, match1;
  logic [15:0] cnt0;
  logic [1:0] cnt1, st0, st1;
  always #5 clk = ~clk;
  seq_det_prog #(.MAX_LEN(8), .CNT_W(16), .MEALY(0)) u0 (
    .clk(clk), .rst(rst), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern), .cfg_len_i(cfg_len),
    .cfg_overlap_i(cfg_overlap), .in_valid_i(in_valid), .in_bit_i(in_bit), .cnt_clr_i(cnt_clr),
    .match_o(match0), .match_count_o(cnt0), .det_state_o(st0));
  seq_det_prog #(.MAX_LEN(8), .CNT_W(2), .MEALY(0)) u1 (
    .clk(clk), .rst(rst), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern), .cfg_len_i(cfg_len),
    .cfg_overlap_i(cfg_overlap), .in_valid_i(in_valid), .in_bit_i(in_bit), .cnt_clr_i(cnt_clr),
    .match_o(match1), .match_count_o(cnt1), .det_state_o(st1));
  typedef struct {
    logic r, l;
    logic [7:0] p;
    logic [3:0] n;
    logic o, v, b, c, h;
    logic [1:0] s;
  } vec_t;
  vec_t tbl[$];
  logic exp_q[$];
  int checks = 0, errors = 0;
  logic [15:0] ec0;
  logic [1:0] ec1;
  function automatic void add(input logic r, l, input logic [7:0] p, input logic [3:0] n,
                              input logic o, v, b, c, h, input logic [1:0] s);
    tbl.push_back('{r, l, p, n, o, v, b, c, h, s});
  endfunction
  function automatic void bt(input logic b, h, input logic [1:0] s);
    add(0, 0, 8'h00, 4'd0, 0, 1, b, 0, h, s);
  endfunction
  function automatic void ld(input logic [7:0] p, input logic [3:0] n, input logic o);
    add(0, 1, p, n, o, 0, 0, 0, 0, 2'd1);
  endfunction
  function automatic void idle(input logic [1:0] s);
    add(0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, s);
  endfunction
  function automatic void rs();
    add(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 2'd0);
  endfunction
  task automatic chk(input string nm, input int i, input logic [15:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", nm, i, act, exp);
    end
  endtask
  initial begin
    vec_t t;
    logic h;
    rs();
    repeat (10) bt(1, 0, 0);
    ld(8'b110, 3, 0);
    bt(1, 0, 1); bt(1, 0, 1); bt(0, 1, 1); bt(1, 0, 1); bt(1, 0, 1); bt(0, 1, 1);
    ld(8'hF, 4, 1);
    repeat (3) bt(1, 0, 1);
    repeat (4) bt(1, 1, 2);
    ld(8'hF, 4, 0);
    repeat (3) bt(1, 0, 1);
    bt(1, 1, 1);
    repeat (3) bt(1, 0, 1);
    ld(8'b110, 3, 0);
    bt(1, 0, 1); idle(1); bt(1, 0, 1); idle(1); idle(1); bt(0, 1, 1);
    idle(1); idle(1); idle(1); bt(1, 0, 1); bt(1, 0, 1); idle(1); bt(0, 1, 1);
    ld(8'b110, 3, 0);
    bt(1, 0, 1); bt(1, 0, 1);
    add(0, 1, 8'b110, 4'd3, 0, 1, 0, 0, 0, 2'd1);
    bt(1, 0, 1); bt(1, 0, 1); bt(0, 1, 1);
    add(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 2'd1);
    bt(1, 0, 1); bt(1, 0, 1);
    add(0, 0, 8'h00, 4'd0, 0, 1, 0, 1, 1, 2'd1);
    ld(8'h01, 0, 0);
    bt(1, 1, 1); bt(0, 0, 2); bt(1, 1, 1); bt(1, 1, 1);
    rs();
    bt(1, 0, 0);
    ld(8'hA5, 15, 1);
    bt(1, 0, 1); bt(0, 0, 1); bt(1, 0, 1); bt(0, 0, 1); bt(0, 0, 1); bt(1, 0, 1); bt(0, 0, 1);
    bt(1, 1, 2); bt(1, 0, 2);
    ec0 = '0;
    ec1 = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      rst = t.r; cfg_load = t.l; cfg_pattern = t.p; cfg_len = t.n; cfg_overlap = t.o;
      in_valid = t.v; in_bit = t.v ? t.b : 1'($urandom); cnt_clr = t.c;
      exp_q.push_back(t.h);
      if (t.r || t.c) begin
        ec0 = '0;
        ec1 = '0;
      end else if (t.h) begin
        if (ec0 != 16'hFFFF) ec0 = ec0 + 16'd1;
        if (ec1 != 2'd3) ec1 = ec1 + 2'd1;
      end
      @(posedge clk);
      #1;
      h = exp_q.pop_front();
      chk("match", i, {15'd0, match0}, {15'd0, h});
      chk("match_c2", i, {15'd0, match1}, {15'd0, h});
      chk("state", i, {14'd0, st0}, {14'd0, t.s});
      chk("state_c2", i, {14'd0, st1}, {14'd0, t.s});
      chk("count", i, cnt0, ec0);
      chk("count_c2", i, {14'd0, cnt1}, {14'd0, ec1});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
